// File: rtl/mux_2x1.sv
// Registered 2:1 lane selector with a valid qualifier; 1-cycle latency, no combinational input-to-output path.
// There is no backpressure: every valid cycle is captured, and an idle cycle holds dout and clears out_valid.
module mux_2x1 #(
   parameter int WIDTH = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               sel,
   input  logic [2*WIDTH-1:0] din,
   input  logic               in_valid,
   output logic [WIDTH-1:0]   dout,
   output logic               out_valid
);

   logic [WIDTH-1:0] w_lane0;
   logic [WIDTH-1:0] w_lane1;
   logic [WIDTH-1:0] w_sel_dat;
   logic [WIDTH-1:0] r_dout;
   logic             r_out_valid;

   assign w_lane0   = din[WIDTH-1:0];
   assign w_lane1   = din[2*WIDTH-1:WIDTH];
   assign w_sel_dat = sel ? w_lane1 : w_lane0;

   // dout only loads on valid cycles; out_valid tracks in_valid one edge later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dout      <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_dout <= w_sel_dat;
         end
      end
   end

   assign dout      = r_dout;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_2x1.sv
// Bench for mux_2x1 at WIDTH=1 and WIDTH=8; expected lanes are queued at issue and popped when out_valid rises.
module tb_mux_2x1;

   logic        clk;
   logic        rst_n;

   logic        sel1;
   logic [1:0]  din1;
   logic        vld1;
   logic        dout1;
   logic        ov1;

   logic        sel8;
   logic [15:0] din8;
   logic        vld8;
   logic [7:0]  dout8;
   logic        ov8;

   logic        q1[$];
   logic [7:0]  q8[$];

   int n_pass;
   int n_total;

   mux_2x1 #(.WIDTH(1)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .sel       (sel1),
      .din       (din1),
      .in_valid  (vld1),
      .dout      (dout1),
      .out_valid (ov1)
   );

   mux_2x1 #(.WIDTH(8)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .sel       (sel8),
      .din       (din8),
      .in_valid  (vld8),
      .dout      (dout8),
      .out_valid (ov8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   // Monitors: sample on the falling edge, well away from the capture edge
   always @(negedge clk) begin
      logic [7:0] e1;
      if (ov1 === 1'b1) begin
         if (q1.size() == 0) begin
            chk("w1_unexpected_valid", {7'd0, ov1}, 8'd0);
         end else begin
            e1 = {7'd0, q1.pop_front()};
            chk("w1_dout", {7'd0, dout1}, e1);
         end
      end
   end

   always @(negedge clk) begin
      logic [7:0] e8;
      if (ov8 === 1'b1) begin
         if (q8.size() == 0) begin
            chk("w8_unexpected_valid", {7'd0, ov8}, 8'd0);
         end else begin
            e8 = q8.pop_front();
            chk("w8_dout", dout8, e8);
         end
      end
   end

   task automatic step1(input logic s, input logic [1:0] d, input logic exp);
      sel1 = s; din1 = d; vld1 = 1'b1;
      vld8 = 1'b0;
      q1.push_back(exp);
      @(posedge clk); #1;
   endtask

   task automatic step8(input logic s, input logic [15:0] d, input logic [7:0] exp);
      sel8 = s; din8 = d; vld8 = 1'b1;
      vld1 = 1'b0;
      q8.push_back(exp);
      @(posedge clk); #1;
   endtask

   logic [1:0] sw_din [4];
   logic       sw_e0  [4];
   logic       sw_e1  [4];

   initial begin
      n_pass = 0; n_total = 0;
      sw_din = '{2'b00, 2'b01, 2'b10, 2'b11};
      sw_e0  = '{1'b0, 1'b1, 1'b0, 1'b1};
      sw_e1  = '{1'b0, 1'b0, 1'b1, 1'b1};

      rst_n = 1'b0;
      sel1 = 1'b0; din1 = 2'b00; vld1 = 1'b0;
      sel8 = 1'b0; din8 = 16'h0000; vld8 = 1'b0;
      #2;

      // Reset held: toggled valid inputs must not reach the outputs
      for (int i = 0; i < 3; i++) begin
         sel1 = i[0]; din1 = 2'b11; vld1 = 1'b1;
         sel8 = i[0]; din8 = 16'hFFFF; vld8 = 1'b1;
         @(posedge clk); #1;
         chk("rst_dout1", {7'd0, dout1}, 8'd0);
         chk("rst_ov1",   {7'd0, ov1},   8'd0);
         chk("rst_dout8", dout8,          8'd0);
         chk("rst_ov8",   {7'd0, ov8},   8'd0);
      end

      vld1 = 1'b0; vld8 = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_dout8", dout8,        8'd0);
      chk("post_rst_ov8",   {7'd0, ov8}, 8'd0);
      chk("post_rst_ov1",   {7'd0, ov1}, 8'd0);

      for (int i = 0; i < 4; i++) step1(1'b0, sw_din[i], sw_e0[i]);
      for (int i = 0; i < 4; i++) step1(1'b1, sw_din[i], sw_e1[i]);

      step8(1'b0, 16'hA55A, 8'h5A);
      step8(1'b1, 16'hA55A, 8'hA5);
      step8(1'b0, 16'h3CC3, 8'hC3);
      step8(1'b1, 16'h3CC3, 8'h3C);

      // Valid gating: capture then idle with changed din must hold dout
      step1(1'b0, 2'b01, 1'b1);
      vld1 = 1'b0; din1 = 2'b10; sel1 = 1'b0;
      @(posedge clk); #1;
      chk("hold_dout1", {7'd0, dout1}, 8'd1);
      chk("hold_ov1",   {7'd0, ov1},   8'd0);

      step8(1'b1, 16'h7E81, 8'h7E);
      vld8 = 1'b0; din8 = 16'h0000; sel8 = 1'b0;
      @(posedge clk); #1;
      chk("hold_dout8", dout8,        8'h7E);
      chk("hold_ov8",   {7'd0, ov8}, 8'd0);

      // Async reset pulse between edges, after the monitors have sampled
      step8(1'b1, 16'hA55A, 8'hA5);
      #5;
      rst_n = 1'b0;
      #1;
      chk("async_dout8", dout8,          8'd0);
      chk("async_ov8",   {7'd0, ov8},   8'd0);
      chk("async_dout1", {7'd0, dout1}, 8'd0);
      chk("async_ov1",   {7'd0, ov1},   8'd0);
      #1;
      rst_n = 1'b1;
      step8(1'b0, 16'hA55A, 8'h5A);
      step1(1'b1, 2'b10, 1'b1);

      vld1 = 1'b0; vld8 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("q1_drained", 8'(q1.size()), 8'd0);
      chk("q8_drained", 8'(q8.size()), 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
